mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates one single-ported main memory between the instruction-fetch requester and the data-access requester, so one memory instance can serve both. Req/ack handshake per requester. The FSM fixes memory access latency, registers read data, and forces one transaction at a time. Sits between the CPU's fetch/load-store paths and a single memory module instance.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
MEM_LATENCY, 2, memory read latency in cycles; legal range 1..15

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request; held high until if_ack seen
if_addr  input  ADDR_W  fetch address
if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  output  DATA_W  registered fetch data
d_req  input  1  data request; held high until d_ack seen
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_ack  output  1  one-cycle pulse: data access complete
d_rdata  output  DATA_W  registered load data
mem_addr  output  ADDR_W  memory address
mem_read_en  output  1  memory read enable
mem_write_en  output  1  memory write enable
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high in BUSY and DONE
owner  output  1  current/last grant: 0 = fetch, 1 = data

Behaviour:
- Reset (rst high at posedge): state IDLE. All outputs 0: acks, rdata regs, mem_*, busy, owner. Latched request regs cleared. Reset has priority over every other event.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no req: mem_read_en = mem_write_en = 0. State stays IDLE.
- IDLE, any req at posedge: pick winner. Latch winner's addr, we and wdata. Set owner. Load cnt = MEM_LATENCY-1. Go to BUSY.
- Default priority: d_req beats if_req.
- BUSY: mem_addr and mem_wdata driven from latched registers.
  - Read: mem_read_en high for every BUSY cycle.
  - Write: mem_write_en high only in the first BUSY cycle (single write pulse); mem_read_en stays 0.
  - BUSY always lasts exactly MEM_LATENCY cycles, reads and writes alike.
  - At the posedge that ends the last BUSY cycle: a read captures mem_rdata into if_rdata or d_rdata (per owner), then go to DONE.
- DONE: owner's ack high for exactly one cycle; mem enables 0; next state IDLE.
- Latency: request accepted at the edge ending cycle t → ack high in cycle t+MEM_LATENCY+1. Next accept is possible at the edge ending cycle t+MEM_LATENCY+2.
- Handshake: requester deasserts req in the cycle after the ack cycle. A req still high in IDLE is a new transaction. Address/data changes while req is high and not yet accepted are taken at accept; changes after accept are ignored.
- Rdata hold: if_rdata and d_rdata change only on a completed read of their own port. d_rdata is unchanged by writes.
- The losing request stays pending and needs no re-assertion.
- Reset mid-operation: transaction aborted, no ack issued. A write pulse already issued is not undone.
- cnt is 4 bits and never wraps: values above 15 are not legal.

Optional Feature:
RR_FAIR_EN: when defined, priority alternates only when both requests are pending at the accept edge. The winner is the port opposite to the last owner. A lone requester is always served. When undefined, fixed data-over-fetch priority applies, and continuous d_req starves fetch.

Test Plan:
1. Reset for 2 cycles with if_req = d_req = 1 → all outputs 0 during reset and on the edge it drops; first accept on the next edge.
2. MEM_LATENCY = 2, fetch if_addr = 0x10, memory returns 0x8C010004 → mem_read_en high in t+1 and t+2 with mem_addr = 0x10; if_ack in t+3 with if_rdata = 0x8C010004; d_ack stays 0.
3. Data write d_addr = 0x40, d_wdata = 0xDEADBEEF → mem_write_en pulse in t+1 only, with mem_addr = 0x40 and mem_wdata = 0xDEADBEEF; d_ack in t+3; d_rdata unchanged.
4. if_req and d_req rise in the same cycle (data read, addr 0x80 → 0x1234) → d_ack in t+3 with d_rdata = 0x1234; fetch accepted at the edge ending t+4; if_ack in t+7.
5. Both reqs held for 4 transactions → without RR_FAIR_EN owner sequence is 1,1,1,1 and if_ack never fires; with RR_FAIR_EN the sequence is 1,0,1,0.
6. rst asserted in the second BUSY cycle of a read → no ack, busy = 0 next cycle; a fresh if_req afterwards completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals for mem_port_arbiter.
// master = CPU/memory environment side, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_read_en,
               mem_write_en, mem_wdata, busy, owner
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_read_en,
               mem_write_en, mem_wdata, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters, one transaction at a time.
// Define RR_FAIR_EN to alternate grants when both ports contend; default is data-over-fetch.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              owner_q;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              any_req;
    logic              grant_d;
    logic              in_busy;

    always_comb begin
        any_req = bus.if_req | bus.d_req;
`ifdef RR_FAIR_EN
        // Contention goes to the port that did not own the last grant.
        grant_d = (bus.if_req && bus.d_req) ? ~owner_q : bus.d_req;
`else
        grant_d = bus.d_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_q    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner_q   <= grant_d;
                    lat_addr  <= grant_d ? bus.d_addr : bus.if_addr;
                    lat_we    <= grant_d & bus.d_we;
                    lat_wdata <= grant_d ? bus.d_wdata : '0;
                    cnt       <= CNT_INIT;
                    state     <= BUSY;
                end
                BUSY: begin
                    // Writes also occupy the full latency window so timing is uniform.
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            if (owner_q) d_rdata_q  <= bus.mem_rdata;
                            else         if_rdata_q <= bus.mem_rdata;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_busy          = (state == BUSY);
    assign bus.mem_addr     = in_busy ? lat_addr  : '0;
    assign bus.mem_wdata    = in_busy ? lat_wdata : '0;
    assign bus.mem_read_en  = in_busy & ~lat_we;
    // Single write strobe on the first BUSY cycle only.
    assign bus.mem_write_en = in_busy & lat_we & (cnt == CNT_INIT);
    assign bus.if_ack       = (state == DONE) & ~owner_q;
    assign bus.d_ack        = (state == DONE) &  owner_q;
    assign bus.busy         = (state != IDLE);
    assign bus.owner        = owner_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Environment memory: reloads its seed image whenever reset is high.
    logic [DW-1:0] seed_mem [0:63];
    logic [DW-1:0] env_mem  [0:63];
    logic [DW-1:0] ref_mem  [0:63];
    assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= seed_mem[i];
        end else if (bus.mem_write_en) begin
            env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit            m_owner;
    logic [DW-1:0] exp_if;
    logic [DW-1:0] exp_d;

    function automatic bit exp_winner(input bit rq_if, input bit rq_d);
`ifdef RR_FAIR_EN
        if (rq_if && rq_d) return !m_owner;
`endif
        return rq_d;
    endfunction

    task automatic model_reset();
        m_owner = 1'b0;
        exp_if  = '0;
        exp_d   = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = seed_mem[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Observation results of run_reqs
    int            o_kif, o_kd, o_nrd, o_nwr, o_nifack, o_ndack;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;

    // Raise the chosen requests, drop each at its ack, record what happened (no judging here).
    task automatic run_reqs(input bit use_if, input bit use_d, input int bound);
        bit first = 1'b1;
        o_kif = -1; o_kd = -1; o_nrd = 0; o_nwr = 0; o_nifack = 0; o_ndack = 0;
        o_addr = '0; o_wdata = '0;
        bus.if_req = use_if;
        bus.d_req  = use_d;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (first && (bus.mem_read_en || bus.mem_write_en)) begin
                o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; first = 1'b0;
            end
            o_nrd += int'(bus.mem_read_en);
            o_nwr += int'(bus.mem_write_en);
            if (bus.if_ack) begin o_nifack++; if (o_kif < 0) o_kif = k; bus.if_req = 1'b0; end
            if (bus.d_ack)  begin o_ndack++;  if (o_kd  < 0) o_kd  = k; bus.d_req  = 1'b0; end
            if ((!use_if || o_kif >= 0) && (!use_d || o_kd >= 0)) break;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        o_nifack += int'(bus.if_ack);
        o_ndack  += int'(bus.d_ack);
    endtask

    task automatic test_reset();
        logic [2*AW+3*DW+5-1:0] outs;
        int kd = -1;
        bit saw_if = 1'b0;
        bus.if_addr = 32'h10; bus.d_addr = 32'h80; bus.d_we = 1'b0; bus.d_wdata = '0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            outs = {bus.if_ack, bus.d_ack, bus.mem_read_en, bus.mem_write_en, bus.busy,
                    bus.mem_addr, bus.if_rdata, bus.d_rdata, bus.mem_wdata, 31'd0, bus.owner};
            n_cmp++;
            if (outs !== '0) begin n_err++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, outs); end
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.owner} !== 2'b11) begin
            n_err++; $display("FAIL reset_first_accept: busy/owner got %b expected 11", {bus.busy, bus.owner});
        end
        bus.if_req = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            saw_if |= bus.if_ack;
            if (bus.d_ack) begin kd = k; bus.d_req = 1'b0; break; end
        end
        @(negedge clk);
        saw_if |= bus.if_ack;
        m_owner = 1'b1; exp_d = ref_mem[32];
        n_cmp++;
        if (kd !== LAT + 1) begin n_err++; $display("FAIL reset_d_ack_cycle: got %0d expected %0d", kd, LAT + 1); end
        n_cmp++;
        if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL reset_d_rdata: got %h expected %h", bus.d_rdata, exp_d); end
        n_cmp++;
        if ({saw_if, bus.busy} !== 2'b00) begin n_err++; $display("FAIL reset_idle_after: if_ack/busy got %b expected 00", {saw_if, bus.busy}); end
    endtask

    task automatic test_fetch_read();
        bus.if_addr = 32'h10;
        run_reqs(1'b1, 1'b0, 20);
        exp_if = ref_mem[4]; m_owner = 1'b0;
        n_cmp++;
        if ({o_kif, o_kd} !== {LAT + 1, -1}) begin n_err++; $display("FAIL fetch_ack_cycle: got if=%0d d=%0d expected if=%0d d=-1", o_kif, o_kd, LAT + 1); end
        n_cmp++;
        if ({o_nrd, o_nwr, o_nifack, o_ndack} !== {LAT, 0, 1, 0}) begin
            n_err++; $display("FAIL fetch_strobes: rd=%0d wr=%0d ifack=%0d dack=%0d expected %0d/0/1/0", o_nrd, o_nwr, o_nifack, o_ndack, LAT);
        end
        n_cmp++;
        if (o_addr !== 32'h10) begin n_err++; $display("FAIL fetch_mem_addr: got %h expected 00000010", o_addr); end
        n_cmp++;
        if ({bus.if_rdata, bus.d_rdata} !== {exp_if, exp_d}) begin
            n_err++; $display("FAIL fetch_rdata: got if=%h d=%h expected if=%h d=%h", bus.if_rdata, bus.d_rdata, exp_if, exp_d);
        end
    endtask

    task automatic test_data_write();
        bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF; bus.d_we = 1'b1;
        run_reqs(1'b0, 1'b1, 20);
        ref_mem[16] = 32'hDEADBEEF; m_owner = 1'b1;
        n_cmp++;
        if ({o_kif, o_kd} !== {-1, LAT + 1}) begin n_err++; $display("FAIL write_ack_cycle: got if=%0d d=%0d expected d=%0d", o_kif, o_kd, LAT + 1); end
        n_cmp++;
        if ({o_nrd, o_nwr, o_ndack} !== {0, 1, 1}) begin n_err++; $display("FAIL write_strobes: rd=%0d wr=%0d dack=%0d expected 0/1/1", o_nrd, o_nwr, o_ndack); end
        n_cmp++;
        if ({o_addr, o_wdata} !== {32'h40, 32'hDEADBEEF}) begin n_err++; $display("FAIL write_bus: got %h/%h expected 00000040/deadbeef", o_addr, o_wdata); end
        n_cmp++;
        if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL write_d_rdata_hold: got %h expected %h", bus.d_rdata, exp_d); end
        bus.d_we = 1'b0; bus.d_wdata = '0;
        run_reqs(1'b0, 1'b1, 20);
        exp_d = ref_mem[16];
        n_cmp++;
        if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL write_readback: got %h expected %h", bus.d_rdata, exp_d); end
    endtask

    task automatic test_simultaneous();
        bit w;
        bus.d_addr = 32'h80; bus.d_we = 1'b0; bus.if_addr = 32'h20;
        w = exp_winner(1'b1, 1'b1);
        run_reqs(1'b1, 1'b1, 30);
        exp_d = ref_mem[32]; exp_if = ref_mem[8]; m_owner = !w;
        n_cmp++;
        if ({o_kd, o_kif} !== (w ? {LAT + 1, 2 * LAT + 3} : {2 * LAT + 3, LAT + 1})) begin
            n_err++; $display("FAIL simul_ack_cycles: got d=%0d if=%0d (data first expected=%0d)", o_kd, o_kif, w);
        end
        n_cmp++;
        if ({bus.d_rdata, bus.if_rdata} !== {exp_d, exp_if}) begin
            n_err++; $display("FAIL simul_rdata: got d=%h if=%h expected d=%h if=%h", bus.d_rdata, bus.if_rdata, exp_d, exp_if);
        end
    endtask

    task automatic test_both_held();
        logic [3:0] got_seq = '0;
        logic [3:0] exp_seq = '0;
        int nack = 0;
        int nif = 0;
        int exp_nif = 0;
        bit w;
        do_reset();
        bus.if_addr = 32'h10; bus.d_addr = 32'h80; bus.d_we = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 80 && nack < 4; k++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) begin
                got_seq[nack] = bus.d_ack;
                nif += int'(bus.if_ack);
                nack++;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w = exp_winner(1'b1, 1'b1);
            exp_seq[i] = w; m_owner = w;
            if (w) exp_d = ref_mem[32];
            else begin exp_if = ref_mem[4]; exp_nif++; end
        end
        n_cmp++;
        if (nack !== 4) begin n_err++; $display("FAIL held_ack_count: got %0d expected 4", nack); end
        n_cmp++;
        if (got_seq !== exp_seq) begin n_err++; $display("FAIL held_owner_seq: got %b expected %b (bit0 first)", got_seq, exp_seq); end
        n_cmp++;
        if (nif !== exp_nif) begin n_err++; $display("FAIL held_if_acks: got %0d expected %0d", nif, exp_nif); end
        n_cmp++;
        if ({bus.if_rdata, bus.d_rdata} !== {exp_if, exp_d}) begin
            n_err++; $display("FAIL held_rdata: got if=%h d=%h expected if=%h d=%h", bus.if_rdata, bus.d_rdata, exp_if, exp_d);
        end
    endtask

    task automatic test_reset_mid();
        bus.if_addr = 32'h24;
        bus.if_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({bus.busy, bus.if_ack, bus.d_ack, bus.mem_read_en, bus.owner} !== 5'b0) begin
            n_err++; $display("FAIL midreset_state: busy/ifack/dack/rd/owner got %b expected 00000",
                              {bus.busy, bus.if_ack, bus.d_ack, bus.mem_read_en, bus.owner});
        end
        n_cmp++;
        if ({bus.if_rdata, bus.d_rdata} !== {exp_if, exp_d}) begin
            n_err++; $display("FAIL midreset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.d_rdata);
        end
        run_reqs(1'b1, 1'b0, 20);
        exp_if = ref_mem[9]; m_owner = 1'b0;
        n_cmp++;
        if ({o_kif, o_nifack} !== {LAT + 1, 1}) begin n_err++; $display("FAIL midreset_refetch: ack cycle %0d count %0d expected %0d/1", o_kif, o_nifack, LAT + 1); end
        n_cmp++;
        if (bus.if_rdata !== exp_if) begin n_err++; $display("FAIL midreset_refetch_data: got %h expected %h", bus.if_rdata, exp_if); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int mode = $urandom_range(1, 3);
            bit use_if = mode[0];
            bit use_d  = mode[1];
            int iidx = $urandom_range(0, 63);
            int didx = $urandom_range(0, 63);
            bit we = $urandom_range(0, 1) == 1;
            logic [DW-1:0] wd = $urandom;
            int e_kif = -1, e_kd = -1, e_rd = 0, e_wr = 0;
            bit w, d_first;
            bus.if_addr = {24'd0, 6'(iidx), 2'b00};
            bus.d_addr  = {24'd0, 6'(didx), 2'b00};
            bus.d_we = we; bus.d_wdata = wd;
            w = exp_winner(use_if, use_d);
            d_first = use_d && w;
            if (use_d) e_kd = (d_first || !use_if) ? LAT + 1 : 2 * LAT + 3;
            if (use_if) e_kif = (!d_first) ? LAT + 1 : 2 * LAT + 3;
            for (int s = 0; s < 2; s++) begin
                bit serve_d = (s == 0) ? d_first : !d_first;
                if (serve_d && use_d) begin
                    if (we) begin ref_mem[didx] = wd; e_wr++; end
                    else begin exp_d = ref_mem[didx]; e_rd += LAT; end
                    m_owner = 1'b1;
                end else if (!serve_d && use_if) begin
                    exp_if = ref_mem[iidx]; e_rd += LAT; m_owner = 1'b0;
                end
            end
            run_reqs(use_if, use_d, 30);
            n_cmp++;
            if ({o_kif, o_kd} !== {e_kif, e_kd}) begin
                n_err++; $display("FAIL rand%0d_ack_cycles: got if=%0d d=%0d expected if=%0d d=%0d", it, o_kif, o_kd, e_kif, e_kd);
            end
            n_cmp++;
            if ({o_nrd, o_nwr, o_nifack, o_ndack} !== {e_rd, e_wr, int'(use_if), int'(use_d)}) begin
                n_err++; $display("FAIL rand%0d_strobes: rd=%0d wr=%0d ifack=%0d dack=%0d expected %0d/%0d/%0d/%0d",
                                  it, o_nrd, o_nwr, o_nifack, o_ndack, e_rd, e_wr, use_if, use_d);
            end
            n_cmp++;
            if ({bus.if_rdata, bus.d_rdata} !== {exp_if, exp_d}) begin
                n_err++; $display("FAIL rand%0d_rdata: got if=%h d=%h expected if=%h d=%h", it, bus.if_rdata, bus.d_rdata, exp_if, exp_d);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 64; i++) seed_mem[i] = $urandom;
        seed_mem[4]  = 32'h8C010004;
        seed_mem[32] = 32'h00001234;
        model_reset();
        test_reset();
        test_fetch_read();
        test_data_write();
        test_simultaneous();
        test_both_held();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
